// File: rtl/fwd_hazard_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Forwarding and load-use hazard unit for a classic 5-stage pipeline.
//   Produces the 2-bit select codes for the EX-stage operand A/B forwarding
//   multiplexers and requests a one-cycle stall (PC + IF/ID hold, EX bubble)
//   when the instruction in ID needs the result of a load that is in EX.
//   The unit keeps its own shadow copy of the EX, MEM and WB destination
//   metadata, so it only needs the ID decode fields and pipeline control.
//
//   Select encoding (matches the mux input order):
//     0 = register-file value
//     1 = MEM/WB write-back value
//     2 = EX/MEM ALU result
//     3 = never driven
//
// Parameters:
//   RA_W   register address width
//   CNT_W  statistics counter width (present only with FWD_STATS_EN)
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   asynchronous, active-high reset
//   id_valid     in   ID holds a real instruction
//   id_rs        in   ID source register 1
//   id_rt        in   ID source register 2
//   id_dest      in   ID destination register (already muxed rd/rt)
//   id_regwrite  in   ID instruction writes the register file
//   id_memread   in   ID instruction is a load
//   flush        in   taken branch/jump, discard the ID instruction
//   ext_stall    in   global freeze (memory wait)
//   forward_a    out  select code for operand A mux
//   forward_b    out  select code for operand B mux
//   stall        out  hold PC and IF/ID, bubble inserted into EX
//   stall_count  out  (FWD_STATS_EN) saturating count of stall cycles
//   fwd_count    out  (FWD_STATS_EN) saturating count of non-frozen cycles
//                     with any operand forwarded
//
// Optional feature:
//   Define FWD_STATS_EN to add the CNT_W parameter and the two statistics
//   counters. Without it the counters and their ports do not exist and all
//   other behaviour is unchanged.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int RA_W = 5
`ifdef FWD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_dest,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            flush,
  input  logic            ext_stall,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic            stall
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_count
`endif
);

  // Shadow pipeline records
  logic [RA_W-1:0] ex_rs_q, ex_rs_d;
  logic [RA_W-1:0] ex_rt_q, ex_rt_d;
  logic [RA_W-1:0] ex_dest_q, ex_dest_d;
  logic            ex_regwrite_q, ex_regwrite_d;
  logic            ex_memread_q, ex_memread_d;
  logic [RA_W-1:0] mem_dest_q, mem_dest_d;
  logic            mem_regwrite_q, mem_regwrite_d;
  logic [RA_W-1:0] wb_dest_q, wb_dest_d;
  logic            wb_regwrite_q, wb_regwrite_d;

  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic hazard;

  // Forward selects depend on registered state only. The MEM stage holds the
  // newer value, so its match takes priority over WB. Register 0 is
  // hard-wired, so a zero destination never forwards.
  always_comb begin
    mem_hit_a = mem_regwrite_q && (mem_dest_q != '0) && (mem_dest_q == ex_rs_q);
    mem_hit_b = mem_regwrite_q && (mem_dest_q != '0) && (mem_dest_q == ex_rt_q);
    wb_hit_a  = wb_regwrite_q  && (wb_dest_q  != '0) && (wb_dest_q  == ex_rs_q);
    wb_hit_b  = wb_regwrite_q  && (wb_dest_q  != '0) && (wb_dest_q  == ex_rt_q);

    forward_a = 2'd0;
    if (mem_hit_a)     forward_a = 2'd2;
    else if (wb_hit_a) forward_a = 2'd1;

    forward_b = 2'd0;
    if (mem_hit_b)     forward_b = 2'd2;
    else if (wb_hit_b) forward_b = 2'd1;
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time. A flush already kills the ID instruction and a freeze holds
  // everything, so neither needs an extra stall.
  always_comb begin
    hazard = ex_memread_q && (ex_dest_q != '0) && id_valid &&
             ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));
    stall  = hazard && !flush && !ext_stall;
  end

  // Next-state for the shadow records: freeze holds all, otherwise the
  // records advance and EX takes either the ID fields or a bubble.
  always_comb begin
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_dest_d      = ex_dest_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_dest_d     = mem_dest_q;
    mem_regwrite_d = mem_regwrite_q;
    wb_dest_d      = wb_dest_q;
    wb_regwrite_d  = wb_regwrite_q;

    if (!ext_stall) begin
      wb_dest_d      = mem_dest_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_dest_d     = ex_dest_q;
      mem_regwrite_d = ex_regwrite_q;
      if (flush || stall || !id_valid) begin
        ex_rs_d       = '0;
        ex_rt_d       = '0;
        ex_dest_d     = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
      end else begin
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
        ex_dest_d     = id_dest;
        ex_regwrite_d = id_regwrite;
        ex_memread_d  = id_memread;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

  // Saturating statistics: one fwd_count tick per cycle regardless of how
  // many operands are forwarded, and none while the pipeline is frozen.
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    if (!ext_stall && ((forward_a != 2'd0) || (forward_b != 2'd0)) &&
        (fwd_count_q != '1)) begin
      fwd_count_d = fwd_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule
